muldiv_seq: RTL and testbench

- Multi-cycle RV32M multiply/divide sequencer in the EX stage, alongside the single-cycle integer ALU.
- Accepts one M-extension operation and iterates radix-2 shift-add (multiply) or restoring subtract (divide) over 32 cycles.
- Exposes busy/done so the hazard unit stalls the pipeline until the result is ready.
- Also handles signed/unsigned operand fix-up and the RISC-V special cases (divide by zero, signed overflow).

---
 rtl/muldiv_seq_pkg.sv | 35 +++
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 164 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 op encoding,
// FSM states and operand sign helpers.
package rv32i_types;

    typedef enum logic [2:0] {
        m_mul    = 3'b000,
        m_mulh   = 3'b001,
        m_mulhsu = 3'b010,
        m_mulhu  = 3'b011,
        m_div    = 3'b100,
        m_divu   = 3'b101,
        m_rem    = 3'b110,
        m_remu   = 3'b111
    } muldiv_ops;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_ops op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input muldiv_ops op);
        return (op == m_mul) || (op == m_mulh) || (op == m_mulhsu) ||
               (op == m_div) || (op == m_rem);
    endfunction

    function automatic logic op_b_signed(input muldiv_ops op);
        return (op == m_mul) || (op == m_mulh) || (op == m_div) || (op == m_rem);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage (master) and the muldiv sequencer (slave).
interface muldiv_seq_if
    import rv32i_types::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic            start;
    muldiv_ops       op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] f;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, f
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, f
    );

endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and RISC-V divide special cases.
module muldiv_seq
    import rv32i_types::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    muldiv_seq_if.slave  bus
);

    muldiv_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    muldiv_ops         op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;   // product accumulator, or quotient in the low half
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   f_q, f_d;

    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_f;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result;

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.f    = f_q;

    // Accept-time operand conditioning and special-case detection.
    always_comb begin
        sa       = op_a_signed(bus.op) & bus.a[XLEN-1];
        sb       = op_b_signed(bus.op) & bus.b[XLEN-1];
        mag_a    = sa ? (~bus.a + 1'b1) : bus.a;
        mag_b    = sb ? (~bus.b + 1'b1) : bus.b;
        fast_hit = 1'b0;
        fast_f   = '0;
        if (op_is_div(bus.op)) begin
            if (bus.b == '0) begin
                fast_hit = 1'b1;
                fast_f   = bus.op[1] ? bus.a : '1;
            end else if (((bus.op == m_div) || (bus.op == m_rem)) &&
                         (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1)) begin
                fast_hit = 1'b1;
                fast_f   = (bus.op == m_div) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
            end
        end
    end

    // One iteration of each datapath, plus the final sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = qneg_q ? (~mul_next + 1'b1) : mul_next;

        div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = ~div_diff[XLEN];
        rem_next  = div_ge ? div_diff : div_shift;
        quo_next  = {acc_q[XLEN-2:0], div_ge};
        quo_fix   = qneg_q ? (~quo_next + 1'b1) : quo_next;
        rem_fix   = rneg_q ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];

        unique case (op_q)
            m_mul:                   result = prod_fix[XLEN-1:0];
            m_mulh, m_mulhsu, m_mulhu: result = prod_fix[2*XLEN-1:XLEN];
            m_div, m_divu:           result = quo_fix;
            default:                 result = rem_fix;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        opb_d   = opb_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        f_d     = f_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d   = bus.op;
                    cnt_d  = '0;
                    acc_d  = {{XLEN{1'b0}}, mag_a};
                    rem_d  = '0;
                    opb_d  = mag_b;
                    qneg_d = sa ^ sb;
                    rneg_d = sa;
                    if (fast_hit) begin
                        f_d     = fast_f;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_is_div(op_q)) begin
                    acc_d = {{XLEN{1'b0}}, quo_next};
                    rem_d = rem_next;
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    f_d     = result;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A flushed op must never publish a result.
        if (bus.flush) begin
            state_d = IDLE;
            f_d     = f_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= m_mul;
            acc_q   <= '0;
            rem_q   <= '0;
            opb_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opb_q   <= opb_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            f_q     <= f_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table for results/latency, plus flush,
// mid-op reset and held-start sequences.
module tb_muldiv_seq;
    import rv32i_types::*;

    logic clk;
    logic rst;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        muldiv_ops   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[12];
    int          checks;
    int          failures;
    logic [31:0] last_f;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input muldiv_ops op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        check({name, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.done && n < 40) begin
            step();
            n++;
        end
        check({name, " latency"}, n, lat);
        check({name, " f"}, bus.f, exp);
        last_f = exp;
        step();
        check({name, " busy_after_done"}, 32'(bus.busy), 32'd0);
        check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n_done;
        int first_done;
        int second_done;

        checks    = 0;
        failures  = 0;
        last_f    = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = m_mul;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        vecs[0]  = '{"mul_7_m3",     m_mul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vecs[1]  = '{"mulh_min_min", m_mulh,   32'h80000000, 32'h80000000, 32'h40000000, 33};
        vecs[2]  = '{"mulhu_max",    m_mulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[3]  = '{"mulhsu_m1_2",  m_mulhsu, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        vecs[4]  = '{"divu_100_7",   m_divu,   32'd100,      32'd7,        32'd14,       33};
        vecs[5]  = '{"remu_100_7",   m_remu,   32'd100,      32'd7,        32'd2,        33};
        vecs[6]  = '{"div_m7_2",     m_div,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vecs[7]  = '{"rem_m7_2",     m_rem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vecs[8]  = '{"div_by_zero",  m_div,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[9]  = '{"rem_by_zero",  m_rem,    32'd5,        32'd0,        32'd5,        1};
        vecs[10] = '{"div_ovf",      m_div,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{"rem_ovf",      m_rem,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

        step();
        step();
        rst = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset f", bus.f, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Flush ten cycles into a divide.
        bus.start = 1'b1;
        bus.op    = m_divu;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush done", 32'(bus.done), 32'd0);
        check("flush f_held", bus.f, last_f);
        run_op("mul_3_4_after_flush", m_mul, 32'd3, 32'd4, 32'd12, 33);

        // Reset in the middle of CALC.
        bus.start = 1'b1;
        bus.op    = m_mul;
        bus.a     = 32'h12345678;
        bus.b     = 32'd3;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        check("midrst f", bus.f, 32'd0);

        // start held high: one done per op, relaunch only from IDLE after DONE.
        n_done      = 0;
        first_done  = 0;
        second_done = 0;
        bus.start   = 1'b1;
        bus.op      = m_mul;
        bus.a       = 32'd5;
        bus.b       = 32'd6;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (bus.done) begin
                n_done++;
                if (n_done == 1) first_done = i;
                if (n_done == 2) second_done = i;
            end
            if (i == 33) check("held f", bus.f, 32'd30);
            if (i == 34) check("held idle_after_done", 32'(bus.busy), 32'd0);
            if (i == 35) check("held relaunch_busy", 32'(bus.busy), 32'd1);
        end
        check("held first_done_cycle", first_done, 33);
        check("held second_done_cycle", second_done, 67);
        check("held done_count", n_done, 2);
        bus.start = 1'b0;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("final flush busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
